instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
- Control unit that sequences the 32x8 combinational instruction memory for the nibble CPU.
- Drives the memory address from an internal PC and fetches 1- or 2-byte instructions.
- Resolves jumps and branches locally; issues every other instruction to the datapath through a valid/ready handshake.
- Sits between the instruction memory and the ALU/register-file datapath.

Parameters:
- ADDR_W, 5, PC/memory address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 8, instruction byte width; upper nibble is opcode, lower nibble is operand.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable; when low, the sequencer holds in FETCH.
- imem_addr  out  ADDR_W  instruction memory address; equals the registered PC.
- imem_data  in  DATA_W  combinational instruction memory read data.
- flags  in  4  datapath status flags for conditional branches.
- exec_valid  out  1  instruction presented to the datapath.
- exec_ready  in  1  datapath accepts the presented instruction.
- opcode  out  4  registered opcode of the current instruction.
- operand  out  4  registered operand nibble.
- imm  out  DATA_W  registered immediate byte; 0 for 1-byte instructions.
- halted  out  1  high while in HALT.

Behaviour:
- Reset is asynchronous. It sets pc=RESET_PC, state=FETCH, opcode=0, operand=0, imm=0, exec_valid=0, halted=0.
- Reset asserted mid-operation aborts any pending issue immediately.
- Opcode classes:
  - 0x3, 0x4: 2-byte, issued with imm.
  - 0xA: 2-byte conditional branch, not issued.
  - 0xE: 1-byte jump; target is {0, operand} zero-extended to ADDR_W; not issued.
  - 0xF: HALT.
  - All other opcodes: 1-byte, issued with imm=0.
- FETCH:
  - If run=0: hold; no register changes.
  - Otherwise latch opcode/operand from imem_data and clear imm.
  - Opcode 0xE: pc<=target, next state FETCH.
  - Opcode 0xF: next state HALT; pc is not incremented.
  - Other 2-byte opcodes: pc<=pc+1, next state FETCH_IMM.
  - All remaining opcodes: pc<=pc+1, next state ISSUE.
- FETCH_IMM:
  - Latch imm<=imem_data.
  - For 0xA: taken = flags[operand[1:0]] XOR operand[2]. If taken, pc<=imem_data[ADDR_W-1:0]; else pc<=pc+1. Next state FETCH.
  - Otherwise pc<=pc+1, next state ISSUE.
  - run is ignored here.
- ISSUE:
  - exec_valid=1; opcode, operand and imm stay stable.
  - On exec_valid && exec_ready: next state FETCH.
  - exec_valid is registered; it deasserts the cycle after the accepting edge.
  - exec_ready low: hold indefinitely.
- HALT: halted=1, exec_valid=0, pc frozen. Only reset exits.
- Cycle counts:
  - Minimum 2 cycles per issued 1-byte instruction; 3 per 2-byte instruction.
  - Jump takes 1 cycle; branch takes 2 cycles.
- PC increments wrap 31->0. A 2-byte instruction starting at address 31 takes its immediate from address 0.
- imem_addr is driven combinationally from the pc register; there is no path from imem_data to imem_addr.
- exec_ready is ignored outside ISSUE.

Test Plan:
- Reset with run=1, exec_ready=1; memory at 0x00..0x01 = 0x30, 0x05 -> opcode=3, imm=0x05, exec_valid high in cycle 3, imem_addr=2 after issue.
- Memory[0]=0x21, exec_ready held low for 5 cycles -> exec_valid stays high for 6 cycles with opcode=2, operand=1 stable; returns to FETCH at pc=1.
- Program ending with 0xE3 at address 13 -> after the jump cycle imem_addr=3; the loop repeats for 3 iterations with no exec_valid on the jump.
- 0xA1 followed by 0x08: flags=0b0010 -> pc=8; flags=0b0000 -> pc=addr+2. Repeat with 0xA5 (inverted) -> opposite outcomes.
- 0x41 at address 31 with memory[0]=0x7E -> imm=0x7E issued, then pc=1. 0xF0 -> halted=1, pc frozen; run and exec_ready toggling cause no change.
- Assert reset while in ISSUE with exec_ready=0 -> exec_valid drops with no clock edge; pc=0; fetch resumes normally after release.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode sequencer for the nibble CPU: walks the 32x8 instruction memory,
// resolves jumps and branches itself and hands everything else to the datapath.
module instr_fetch_sequencer #(
   parameter int          ADDR_W   = 5,
   parameter int          DATA_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic [3:0]        flags,
   output logic              exec_valid,
   input  logic              exec_ready,
   output logic [3:0]        opcode,
   output logic [3:0]        operand,
   output logic [DATA_W-1:0] imm,
   output logic              halted
);

   typedef enum logic [1:0] {
      FETCH,
      FETCH_IMM,
      ISSUE,
      HALT
   } state_t;

   localparam logic [3:0] OP_IMM_A = 4'h3;
   localparam logic [3:0] OP_IMM_B = 4'h4;
   localparam logic [3:0] OP_BRANCH = 4'hA;
   localparam logic [3:0] OP_JUMP = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [3:0]          r_opcode;
   logic [3:0]          r_operand;
   logic [DATA_W-1:0]   r_imm;
   logic                r_execValid;
   logic                r_halted;

   logic [3:0]          w_fetchOp;
   logic [3:0]          w_fetchOperand;
   logic [ADDR_W-1:0]   w_pcInc;
   logic [ADDR_W-1:0]   w_jumpTarget;
   logic                w_taken;

   assign w_fetchOp      = imem_data[DATA_W-1 -: 4];
   assign w_fetchOperand = imem_data[3:0];
   assign w_pcInc        = r_pc + ADDR_W'(1);
   assign w_jumpTarget   = ADDR_W'(w_fetchOperand);
   // Operand bits [1:0] pick the flag, bit 2 inverts the sense of the test.
   assign w_taken        = flags[r_operand[1:0]] ^ r_operand[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= FETCH;
         r_pc        <= ADDR_W'(RESET_PC);
         r_opcode    <= '0;
         r_operand   <= '0;
         r_imm       <= '0;
         r_execValid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (run) begin
                  r_opcode  <= w_fetchOp;
                  r_operand <= w_fetchOperand;
                  r_imm     <= '0;
                  case (w_fetchOp)
                     OP_JUMP: begin
                        r_pc <= w_jumpTarget;
                     end
                     OP_HALT: begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                     end
                     OP_IMM_A, OP_IMM_B, OP_BRANCH: begin
                        r_pc    <= w_pcInc;
                        r_state <= FETCH_IMM;
                     end
                     default: begin
                        r_pc        <= w_pcInc;
                        r_state     <= ISSUE;
                        r_execValid <= 1'b1;
                     end
                  endcase
               end
            end
            FETCH_IMM: begin
               r_imm <= imem_data;
               if (r_opcode == OP_BRANCH) begin
                  r_pc    <= w_taken ? imem_data[ADDR_W-1:0] : w_pcInc;
                  r_state <= FETCH;
               end else begin
                  r_pc        <= w_pcInc;
                  r_state     <= ISSUE;
                  r_execValid <= 1'b1;
               end
            end
            ISSUE: begin
               if (exec_ready) begin
                  r_execValid <= 1'b0;
                  r_state     <= FETCH;
               end
            end
            HALT: begin
               r_execValid <= 1'b0;
               r_halted    <= 1'b1;
            end
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end

   assign imem_addr  = r_pc;
   assign exec_valid = r_execValid;
   assign opcode     = r_opcode;
   assign operand    = r_operand;
   assign imm        = r_imm;
   assign halted     = r_halted;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboarded bench for instr_fetch_sequencer: expected issues are queued as the
// program is loaded and retired whenever the sequencer hands one to the datapath.
module tb_instr_fetch_sequencer;

   typedef struct {
      logic [3:0] op;
      logic [3:0] opd;
      logic [7:0] imm;
   } issue_t;

   logic       clk;
   logic       reset;
   logic       run;
   logic [4:0] imem_addr;
   logic [7:0] imem_data;
   logic [3:0] flags;
   logic       exec_valid;
   logic       exec_ready;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [7:0] imm;
   logic       halted;

   logic [7:0] mem [32];
   issue_t     expQ [$];
   int         compared;
   int         mismatched;

   instr_fetch_sequencer #(.ADDR_W(5), .DATA_W(8), .RESET_PC(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .flags      (flags),
      .exec_valid (exec_valid),
      .exec_ready (exec_ready),
      .opcode     (opcode),
      .operand    (operand),
      .imm        (imm),
      .halted     (halted)
   );

   assign imem_data = mem[imem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Retire one expected issue for every handshake that the next rising edge accepts.
   always @(negedge clk) begin
      if (!reset && exec_valid && exec_ready) begin
         issue_t e;
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL issue: unexpected op=%h opd=%h imm=%h, none expected", opcode, operand, imm);
         end else begin
            e = expQ.pop_front();
            if ({opcode, operand, imm} !== {e.op, e.opd, e.imm}) begin
               mismatched++;
               $display("[TB] FAIL issue: got %h/%h/%h want %h/%h/%h", opcode, operand, imm, e.op, e.opd, e.imm);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fillHalt();
      for (int i = 0; i < 32; i++) mem[i] = 8'hF0;
      expQ.delete();
   endtask

   task automatic doReset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic pushExp(input logic [3:0] op, input logic [3:0] opd, input logic [7:0] im);
      issue_t e;
      e.op = op;
      e.opd = opd;
      e.imm = im;
      expQ.push_back(e);
   endtask

   task automatic queueEmpty(input string name);
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL %s_drain: %0d issues outstanding, want 0", name, expQ.size());
      end
   endtask

   task automatic test_reset();
      fillHalt();
      mem[0] = 8'h30;
      run = 1'b1;
      exec_ready = 1'b1;
      flags = 4'h0;
      reset = 1'b1;
      #7;
      compared++;
      if ({exec_valid, halted, imem_addr, opcode, operand, imm} !== {1'b0, 1'b0, 5'd0, 4'h0, 4'h0, 8'h00}) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got v=%b h=%b a=%0d op=%h opd=%h imm=%h, want all zero",
                  exec_valid, halted, imem_addr, opcode, operand, imm);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_two_byte();
      fillHalt();
      mem[0] = 8'h30;
      mem[1] = 8'h05;
      run = 1'b1;
      exec_ready = 1'b1;
      pushExp(4'h3, 4'h0, 8'h05);
      doReset();
      tick();
      compared++;
      if (exec_valid !== 1'b0 || imem_addr !== 5'd1) begin
         mismatched++;
         $display("[TB] FAIL two_byte_c1: got v=%b a=%0d want v=0 a=1", exec_valid, imem_addr);
      end
      tick();
      compared++;
      if ({exec_valid, opcode, imm, imem_addr} !== {1'b1, 4'h3, 8'h05, 5'd2}) begin
         mismatched++;
         $display("[TB] FAIL two_byte_c2: got v=%b op=%h imm=%h a=%0d want v=1 op=3 imm=05 a=2",
                  exec_valid, opcode, imm, imem_addr);
      end
      tick();
      compared++;
      if (exec_valid !== 1'b0 || imem_addr !== 5'd2) begin
         mismatched++;
         $display("[TB] FAIL two_byte_c3: got v=%b a=%0d want v=0 a=2", exec_valid, imem_addr);
      end
      run = 1'b0;
      queueEmpty("two_byte");
   endtask

   task automatic test_backpressure();
      fillHalt();
      mem[0] = 8'h21;
      run = 1'b1;
      exec_ready = 1'b0;
      pushExp(4'h2, 4'h1, 8'h00);
      doReset();
      for (int c = 0; c < 6; c++) begin
         tick();
         compared++;
         if ({exec_valid, opcode, operand, imm} !== {1'b1, 4'h2, 4'h1, 8'h00}) begin
            mismatched++;
            $display("[TB] FAIL stall_c%0d: got v=%b op=%h opd=%h imm=%h want v=1 op=2 opd=1 imm=00",
                     c, exec_valid, opcode, operand, imm);
         end
      end
      exec_ready = 1'b1;
      run = 1'b0;
      tick();
      compared++;
      if (exec_valid !== 1'b0 || imem_addr !== 5'd1) begin
         mismatched++;
         $display("[TB] FAIL stall_release: got v=%b a=%0d want v=0 a=1", exec_valid, imem_addr);
      end
      queueEmpty("stall");
   endtask

   task automatic test_jump_loop();
      logic [4:0] prevAddr;
      logic       prevValid;
      int         jumps;
      fillHalt();
      mem[0] = 8'hE3;
      mem[3] = 8'h12;  mem[4] = 8'h3A;  mem[5] = 8'h5C;  mem[6] = 8'h27;
      mem[7] = 8'h40;  mem[8] = 8'h99;  mem[9] = 8'h1F;  mem[10] = 8'h3B;
      mem[11] = 8'h01; mem[12] = 8'h26; mem[13] = 8'hE3;
      for (int it = 0; it < 3; it++) begin
         pushExp(4'h1, 4'h2, 8'h00);
         pushExp(4'h3, 4'hA, 8'h5C);
         pushExp(4'h2, 4'h7, 8'h00);
         pushExp(4'h4, 4'h0, 8'h99);
         pushExp(4'h1, 4'hF, 8'h00);
         pushExp(4'h3, 4'hB, 8'h01);
         pushExp(4'h2, 4'h6, 8'h00);
      end
      run = 1'b1;
      exec_ready = 1'b1;
      doReset();
      tick();
      compared++;
      if (imem_addr !== 5'd3 || exec_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL jump_first: got a=%0d v=%b want a=3 v=0", imem_addr, exec_valid);
      end
      jumps = 0;
      prevAddr = imem_addr;
      prevValid = exec_valid;
      for (int c = 0; c < 120 && jumps < 3; c++) begin
         tick();
         if (prevAddr == 5'd13 && !prevValid) begin
            jumps++;
            compared++;
            if (imem_addr !== 5'd3 || exec_valid !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL jump_%0d: got a=%0d v=%b want a=3 v=0", jumps, imem_addr, exec_valid);
            end
            if (jumps == 3) run = 1'b0;
         end
         prevAddr = imem_addr;
         prevValid = exec_valid;
      end
      compared++;
      if (jumps != 3) begin
         mismatched++;
         $display("[TB] FAIL jump_timeout: got %0d loop jumps want 3", jumps);
         run = 1'b0;
      end
      repeat (2) tick();
      compared++;
      if (imem_addr !== 5'd3 || exec_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL run_hold: got a=%0d v=%b want a=3 v=0", imem_addr, exec_valid);
      end
      queueEmpty("jump_loop");
   endtask

   task automatic test_branch();
      logic [7:0] ops   [6] = '{8'hA1, 8'hA1, 8'hA5, 8'hA5, 8'hA3, 8'hA3};
      logic [3:0] flgs  [6] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0111};
      logic [4:0] wantA [6] = '{5'd8, 5'd2, 5'd2, 5'd8, 5'd8, 5'd2};
      for (int k = 0; k < 6; k++) begin
         fillHalt();
         mem[0] = ops[k];
         mem[1] = 8'h08;
         flags = flgs[k];
         run = 1'b1;
         exec_ready = 1'b1;
         doReset();
         tick();
         tick();
         run = 1'b0;
         compared++;
         if ({imem_addr, exec_valid, opcode, imm} !== {wantA[k], 1'b0, 4'hA, 8'h08}) begin
            mismatched++;
            $display("[TB] FAIL branch_%0d: got a=%0d v=%b op=%h imm=%h want a=%0d v=0 op=a imm=08",
                     k, imem_addr, exec_valid, opcode, imm, wantA[k]);
         end
      end
      flags = 4'h0;
      queueEmpty("branch");
   endtask

   task automatic test_wrap();
      fillHalt();
      mem[0] = 8'h7E;
      mem[1] = 8'hA4;
      mem[2] = 8'h1F;
      mem[31] = 8'h41;
      flags = 4'h0;
      run = 1'b1;
      exec_ready = 1'b1;
      pushExp(4'h7, 4'hE, 8'h00);
      pushExp(4'h4, 4'h1, 8'h7E);
      doReset();
      repeat (4) tick();
      compared++;
      if (imem_addr !== 5'd31) begin
         mismatched++;
         $display("[TB] FAIL wrap_branch: got a=%0d want a=31", imem_addr);
      end
      tick();
      compared++;
      if (imem_addr !== 5'd0) begin
         mismatched++;
         $display("[TB] FAIL wrap_pc: got a=%0d want a=0", imem_addr);
      end
      tick();
      run = 1'b0;
      compared++;
      if ({exec_valid, opcode, operand, imm, imem_addr} !== {1'b1, 4'h4, 4'h1, 8'h7E, 5'd1}) begin
         mismatched++;
         $display("[TB] FAIL wrap_issue: got v=%b op=%h opd=%h imm=%h a=%0d want v=1 op=4 opd=1 imm=7e a=1",
                  exec_valid, opcode, operand, imm, imem_addr);
      end
      repeat (2) tick();
      compared++;
      if (exec_valid !== 1'b0 || imem_addr !== 5'd1) begin
         mismatched++;
         $display("[TB] FAIL wrap_after: got v=%b a=%0d want v=0 a=1", exec_valid, imem_addr);
      end
      queueEmpty("wrap");
   endtask

   task automatic test_halt();
      fillHalt();
      mem[0] = 8'h10;
      mem[1] = 8'hF0;
      run = 1'b1;
      exec_ready = 1'b1;
      pushExp(4'h1, 4'h0, 8'h00);
      doReset();
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         run = i[0];
         exec_ready = i[1];
         tick();
         compared++;
         if ({halted, exec_valid, imem_addr, opcode} !== {1'b1, 1'b0, 5'd1, 4'hF}) begin
            mismatched++;
            $display("[TB] FAIL halt_c%0d: got h=%b v=%b a=%0d op=%h want h=1 v=0 a=1 op=f",
                     i, halted, exec_valid, imem_addr, opcode);
         end
      end
      queueEmpty("halt");
   endtask

   task automatic test_reset_in_issue();
      fillHalt();
      mem[0] = 8'h55;
      run = 1'b1;
      exec_ready = 1'b0;
      doReset();
      tick();
      compared++;
      if (exec_valid !== 1'b1 || imem_addr !== 5'd1) begin
         mismatched++;
         $display("[TB] FAIL abort_pre: got v=%b a=%0d want v=1 a=1", exec_valid, imem_addr);
      end
      #1;
      reset = 1'b1;
      #1;
      compared++;
      if ({exec_valid, imem_addr, halted} !== {1'b0, 5'd0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL abort_async: got v=%b a=%0d h=%b want v=0 a=0 h=0", exec_valid, imem_addr, halted);
      end
      exec_ready = 1'b1;
      pushExp(4'h5, 4'h5, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      compared++;
      if (exec_valid !== 1'b1 || opcode !== 4'h5 || imem_addr !== 5'd1) begin
         mismatched++;
         $display("[TB] FAIL abort_resume: got v=%b op=%h a=%0d want v=1 op=5 a=1", exec_valid, opcode, imem_addr);
      end
      repeat (3) tick();
      compared++;
      if (halted !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_halt: got h=%b want h=1", halted);
      end
      queueEmpty("abort");
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      run = 1'b0;
      exec_ready = 1'b0;
      flags = 4'h0;
      test_reset();
      test_two_byte();
      test_backpressure();
      test_jump_loop();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_in_issue();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
